dac081s101_driver: RTL and testbench

SPI write-side driver for the DAC081S101 8-bit DAC. It accepts one 8-bit sample plus a 2-bit power-down code through a valid/ready handshake. It serialises them as a 16-bit SYNC/SCLK/DIN frame, MSB first, and pulses done when the frame completes. It sits between the application logic and the DAC pins, alongside the existing ADC read-side driver.

---
 rtl/dac081s101_driver_pkg.sv | 30 +++
 rtl/dac081s101_driver_if.sv | 37 +++
 rtl/dac081s101_driver_spi_halfbit_tick.sv | 35 +++
 rtl/dac081s101_driver.sv | 127 ++++++++++++
 tb/tb_dac081s101_driver.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac081s101_driver_pkg.sv
// Shared definitions for the DAC081S101 write-side SPI driver:
// state encodings, frame geometry and the power-down codes.
package dac081s101_driver_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 8;
  localparam int PD_W       = 2;
  localparam int EDGE_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam logic [PD_W-1:0] PD_NORMAL = 2'b00;
  localparam logic [PD_W-1:0] PD_1K     = 2'b01;
  localparam logic [PD_W-1:0] PD_100K   = 2'b10;
  localparam logic [PD_W-1:0] PD_HIZ    = 2'b11;

  // Word layout on the wire: two don't-care zeros, PD1/PD0, sample, four zeros.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [DATA_W-1:0] data,
    input logic [PD_W-1:0]   pd
  );
    return {2'b00, pd, data, 4'b0000};
  endfunction

endpackage

// File: rtl/dac081s101_driver_if.sv
// Application handshake plus DAC pin bundle for the DAC081S101 driver.
// The driver uses the slave modport; the application/bench uses master.
interface dac081s101_driver_if;
  import dac081s101_driver_pkg::*;

  logic              dac_valid;
  logic              dac_ready;
  logic [DATA_W-1:0] dac_data;
  logic [PD_W-1:0]   dac_pd;
  logic              dac_sync;
  logic              dac_sclk;
  logic              dac_din;
  logic              dac_done;

  modport master (
    output dac_valid,
    output dac_data,
    output dac_pd,
    input  dac_ready,
    input  dac_sync,
    input  dac_sclk,
    input  dac_din,
    input  dac_done
  );

  modport slave (
    input  dac_valid,
    input  dac_data,
    input  dac_pd,
    output dac_ready,
    output dac_sync,
    output dac_sclk,
    output dac_din,
    output dac_done
  );

endinterface

// File: rtl/dac081s101_driver_spi_halfbit_tick.sv
// Half-period prescaler: while enabled, pulses tick on the last clk of
// every CLK_DIV-cycle SCLK half-period; held at zero when disabled.
module spi_halfbit_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac081s101_driver.sv
// DAC081S101 write-side driver: accepts sample + PD code, shifts a 16-bit
// MSB-first frame out on SYNC/SCLK/DIN, then holds SYNC high for a gap.
module dac081s101_driver
  import dac081s101_driver_pkg::*;
#(
  parameter int CLK_DIV    = 1,
  parameter int GAP_HALVES = 2
) (
  input logic                clk,
  input logic                rst_n,
  dac081s101_driver_if.slave bus
);

  localparam int GAP_W = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_HALVES - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(FRAME_BITS);

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [EDGE_W-1:0]       edge_q, edge_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    sync_q, sync_d;
  logic                    sclk_q, sclk_d;
  logic                    done_q, done_d;
  logic                    tick;
  logic [FRAME_BITS-1:0]   frame;

  spi_halfbit_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q != ST_IDLE),
    .tick (tick)
  );

  assign frame = build_frame(bus.dac_data, bus.dac_pd);

  // DIN is always the shift register MSB, so clearing the register forces DIN low.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    edge_d  = edge_q;
    gap_d   = gap_q;
    sync_d  = sync_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.dac_valid) begin
          shreg_d = frame;
          sync_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b0;
          edge_d  = EDGE_W'(1);
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          end else if (edge_q == EDGE_LAST) begin
            sync_d  = 1'b1;
            shreg_d = '0;
            edge_d  = '0;
            done_d  = 1'b1;
            state_d = ST_GAP;
          end else begin
            sclk_d = 1'b0;
            edge_d = edge_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      edge_q  <= '0;
      gap_q   <= '0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      edge_q  <= edge_d;
      gap_q   <= gap_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
    end
  end

  assign bus.dac_ready = (state_q == ST_IDLE);
  assign bus.dac_sync  = sync_q;
  assign bus.dac_sclk  = sclk_q;
  assign bus.dac_din   = shreg_q[FRAME_BITS-1];
  assign bus.dac_done  = done_q;

endmodule

// File: tb/tb_dac081s101_driver.sv
// Bench for dac081s101_driver: pin-level SPI receiver models capture each
// frame and are compared against words built from sample/PD inputs.
module tb_dac081s101_driver;
  import dac081s101_driver_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  dac081s101_driver_if bus1();
  dac081s101_driver_if bus4();

  dac081s101_driver #(.CLK_DIV(1), .GAP_HALVES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  dac081s101_driver #(.CLK_DIV(4), .GAP_HALVES(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Accept log and done-pulse counts, as seen at the clock edge.
  int acc1[$];
  int acc4[$];
  int done1 = 0;
  int done4 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus1.dac_valid && bus1.dac_ready) acc1.push_back(cyc);
    if (bus4.dac_valid && bus4.dac_ready) acc4.push_back(cyc);
    if (bus1.dac_done === 1'b1) done1 <= done1 + 1;
    if (bus4.dac_done === 1'b1) done4 <= done4 + 1;
  end

  // SPI receiver model: DIN sampled on SCLK falling edges while SYNC is low.
  logic [15:0] m1_word = '0;
  int          m1_edges = 0;
  logic [15:0] m1_frames[$];
  int          m1_fedges[$];
  logic [15:0] m4_word = '0;
  int          m4_edges = 0;
  logic [15:0] m4_frames[$];
  int          m4_fedges[$];
  time         m4_ft[$];

  always @(negedge bus1.dac_sync) begin
    m1_word  <= '0;
    m1_edges <= 0;
  end
  always @(negedge bus1.dac_sclk) begin
    if (bus1.dac_sync === 1'b0) begin
      m1_word  <= {m1_word[14:0], bus1.dac_din};
      m1_edges <= m1_edges + 1;
    end
  end
  always @(posedge bus1.dac_sync) begin
    if (rst_n === 1'b1) begin
      m1_frames.push_back(m1_word);
      m1_fedges.push_back(m1_edges);
    end
  end

  always @(negedge bus4.dac_sync) begin
    m4_word  <= '0;
    m4_edges <= 0;
  end
  always @(negedge bus4.dac_sclk) begin
    if (bus4.dac_sync === 1'b0) begin
      m4_word  <= {m4_word[14:0], bus4.dac_din};
      m4_edges <= m4_edges + 1;
      m4_ft.push_back($time);
    end
  end
  always @(posedge bus4.dac_sync) begin
    if (rst_n === 1'b1) begin
      m4_frames.push_back(m4_word);
      m4_fedges.push_back(m4_edges);
    end
  end

  function automatic logic [15:0] exp_frame(input logic [7:0] d, input logic [1:0] p);
    logic [15:0] w;
    w = 16'(d) << 4;
    w = w | (16'(p) << 12);
    return w;
  endfunction

  task automatic wait_frames1(input int n, input int budget, output bit ok);
    int k = 0;
    while (m1_frames.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (m1_frames.size() >= n);
  endtask

  task automatic wait_frames4(input int n, input int budget, output bit ok);
    int k = 0;
    while (m4_frames.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (m4_frames.size() >= n);
  endtask

  task automatic wait_ready1(input int budget, output bit ok);
    int k = 0;
    while (bus1.dac_ready !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (bus1.dac_ready === 1'b1);
  endtask

  task automatic test_reset();
    logic [4:0] got1, got4;
    $display("[TB] test_reset");
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      if (i == 2) rst_n = 1'b1;
      got1 = {bus1.dac_sync, bus1.dac_sclk, bus1.dac_din, bus1.dac_done, bus1.dac_ready};
      got4 = {bus4.dac_sync, bus4.dac_sclk, bus4.dac_din, bus4.dac_done, bus4.dac_ready};
      checks += 2;
      if (got1 !== 5'b11001) begin
        errors++;
        $display("[TB] FAIL reset_idle1 cyc %0d: got %b want 11001", i, got1);
      end
      if (got4 !== 5'b11001) begin
        errors++;
        $display("[TB] FAIL reset_idle4 cyc %0d: got %b want 11001", i, got4);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    logic [15:0] f;
    logic [4:0]  got, exp;
    logic        e_sclk, e_din;
    int          idx;
    int          d0;
    $display("[TB] test_single");
    m1_frames.delete();
    m1_fedges.delete();
    f  = exp_frame(8'hA5, PD_NORMAL);
    d0 = done1;
    bus1.dac_data  = 8'hA5;
    bus1.dac_pd    = PD_NORMAL;
    bus1.dac_valid = 1'b1;
    @(negedge clk);
    bus1.dac_valid = 1'b0;
    // Sample i is the cycle after accept edge + i; h_i covers i = 0..32.
    for (int i = 0; i < 40; i++) begin
      e_sclk = (i >= 1 && i <= 32 && (i % 2) == 1) ? 1'b0 : 1'b1;
      idx    = 15 - i / 2;
      e_din  = (i <= 32 && idx >= 0) ? f[idx] : 1'b0;
      exp    = {(i > 32) ? 1'b1 : 1'b0, e_sclk, e_din,
                (i == 33) ? 1'b1 : 1'b0, (i >= 35) ? 1'b1 : 1'b0};
      got    = {bus1.dac_sync, bus1.dac_sclk, bus1.dac_din, bus1.dac_done, bus1.dac_ready};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL single_timing i=%0d {sync,sclk,din,done,ready}: got %b want %b", i, got, exp);
      end
      @(negedge clk);
    end
    checks++;
    if (m1_frames.size() != 1) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d frames want 1", m1_frames.size());
    end else begin
      checks += 2;
      if (m1_frames[0] !== 16'h0A50) begin
        errors++;
        $display("[TB] FAIL single_word: got %h want 0a50", m1_frames[0]);
      end
      if (m1_fedges[0] != 16) begin
        errors++;
        $display("[TB] FAIL single_edges: got %0d want 16", m1_fedges[0]);
      end
    end
    checks++;
    if (done1 - d0 != 1) begin
      errors++;
      $display("[TB] FAIL single_done: got %0d pulses want 1", done1 - d0);
    end
  endtask

  task automatic test_ff_change();
    bit ok;
    $display("[TB] test_ff_change");
    m1_frames.delete();
    m1_fedges.delete();
    wait_ready1(100, ok);
    bus1.dac_data  = 8'hFF;
    bus1.dac_pd    = PD_HIZ;
    bus1.dac_valid = 1'b1;
    @(negedge clk);
    bus1.dac_valid = 1'b0;
    repeat (10) @(negedge clk);
    bus1.dac_data = 8'h00;
    bus1.dac_pd   = PD_NORMAL;
    wait_frames1(1, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL ff_timeout: got no frame want 1 frame");
    end else begin
      checks += 2;
      if (m1_frames[0] !== 16'h3FF0) begin
        errors++;
        $display("[TB] FAIL ff_word: got %h want 3ff0", m1_frames[0]);
      end
      if (m1_fedges[0] != 16) begin
        errors++;
        $display("[TB] FAIL ff_edges: got %0d want 16", m1_fedges[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k;
    int d0;
    $display("[TB] test_back_to_back");
    wait_ready1(100, ok);
    m1_frames.delete();
    m1_fedges.delete();
    acc1.delete();
    d0 = done1;
    bus1.dac_data  = 8'h01;
    bus1.dac_pd    = PD_NORMAL;
    bus1.dac_valid = 1'b1;
    k = 0;
    while (acc1.size() < 2 && k < 100) begin
      @(negedge clk);
      if (acc1.size() == 1) bus1.dac_data = 8'h02;
      k++;
    end
    bus1.dac_valid = 1'b0;
    checks++;
    if (acc1.size() != 2) begin
      errors++;
      $display("[TB] FAIL b2b_accepts: got %0d want 2", acc1.size());
    end else begin
      checks++;
      if (acc1[1] - acc1[0] != 36) begin
        errors++;
        $display("[TB] FAIL b2b_spacing: got %0d want 36", acc1[1] - acc1[0]);
      end
    end
    wait_frames1(2, 80, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL b2b_timeout: got %0d frames want 2", m1_frames.size());
    end else begin
      checks += 4;
      if (m1_frames[0] !== 16'h0010) begin
        errors++;
        $display("[TB] FAIL b2b_word0: got %h want 0010", m1_frames[0]);
      end
      if (m1_frames[1] !== 16'h0020) begin
        errors++;
        $display("[TB] FAIL b2b_word1: got %h want 0020", m1_frames[1]);
      end
      if (m1_fedges[0] != 16 || m1_fedges[1] != 16) begin
        errors++;
        $display("[TB] FAIL b2b_edges: got %0d,%0d want 16,16", m1_fedges[0], m1_fedges[1]);
      end
      if (done1 - d0 != 2) begin
        errors++;
        $display("[TB] FAIL b2b_done: got %0d pulses want 2", done1 - d0);
      end
    end
  endtask

  task automatic test_random();
    bit          ok;
    logic [7:0]  d;
    logic [1:0]  p;
    logic [15:0] exp_q[$];
    $display("[TB] test_random");
    m1_frames.delete();
    m1_fedges.delete();
    for (int n = 0; n < 8; n++) begin
      wait_ready1(100, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL rand_ready n=%0d: got ready=%b want 1", n, bus1.dac_ready);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      d = 8'($urandom);
      p = 2'($urandom);
      exp_q.push_back(exp_frame(d, p));
      bus1.dac_data  = d;
      bus1.dac_pd    = p;
      bus1.dac_valid = 1'b1;
      @(negedge clk);
      bus1.dac_valid = 1'b0;
      bus1.dac_data  = 8'($urandom);
      bus1.dac_pd    = 2'($urandom);
      wait_frames1(n + 1, 60, ok);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (n >= m1_frames.size()) begin
        errors++;
        $display("[TB] FAIL rand_missing n=%0d: got %0d frames want 8", n, m1_frames.size());
      end else if (m1_frames[n] !== exp_q[n] || m1_fedges[n] != 16) begin
        errors++;
        $display("[TB] FAIL rand_word n=%0d: got %h/%0d edges want %h/16",
                 n, m1_frames[n], m1_fedges[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_clkdiv4();
    bit ok;
    int k;
    int low_cnt;
    int d0;
    $display("[TB] test_clkdiv4");
    m4_frames.delete();
    m4_fedges.delete();
    m4_ft.delete();
    acc4.delete();
    d0 = done4;
    low_cnt = 0;
    bus4.dac_data  = 8'h3C;
    bus4.dac_pd    = PD_NORMAL;
    bus4.dac_valid = 1'b1;
    k = 0;
    while (acc4.size() < 2 && k < 400) begin
      @(negedge clk);
      if (acc4.size() == 1 && bus4.dac_sync === 1'b0) low_cnt++;
      k++;
    end
    bus4.dac_valid = 1'b0;
    checks += 2;
    if (low_cnt != 132) begin
      errors++;
      $display("[TB] FAIL div4_sync_low: got %0d clk want 132", low_cnt);
    end
    if (acc4.size() != 2 || acc4[1] - acc4[0] != 145) begin
      errors++;
      $display("[TB] FAIL div4_period: got %0d accepts, spacing %0d want 2, 145",
               acc4.size(), (acc4.size() == 2) ? acc4[1] - acc4[0] : -1);
    end
    wait_frames4(2, 200, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || m4_ft.size() != 32) begin
      errors++;
      $display("[TB] FAIL div4_frames: got %0d frames %0d edges want 2 frames 32 edges",
               m4_frames.size(), m4_ft.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (m4_frames[i] !== 16'h03C0 || m4_fedges[i] != 16) begin
          errors++;
          $display("[TB] FAIL div4_word%0d: got %h/%0d want 03c0/16", i, m4_frames[i], m4_fedges[i]);
        end
      end
      for (int i = 1; i < 16; i++) begin
        checks++;
        if (m4_ft[i] - m4_ft[i-1] != 80) begin
          errors++;
          $display("[TB] FAIL div4_sclk_period e%0d: got %0t want 80", i, m4_ft[i] - m4_ft[i-1]);
        end
      end
      checks += 2;
      if (m4_ft[16] - m4_ft[0] != 1450) begin
        errors++;
        $display("[TB] FAIL div4_frame_spacing: got %0t want 1450", m4_ft[16] - m4_ft[0]);
      end
      if (done4 - d0 != 2) begin
        errors++;
        $display("[TB] FAIL div4_done: got %0d pulses want 2", done4 - d0);
      end
    end
  endtask

  task automatic test_midframe_reset();
    bit         ok;
    int         k;
    logic [4:0] got;
    $display("[TB] test_midframe_reset");
    wait_ready1(100, ok);
    bus1.dac_data  = 8'($urandom);
    bus1.dac_pd    = 2'($urandom);
    bus1.dac_valid = 1'b1;
    @(negedge clk);
    bus1.dac_valid = 1'b0;
    k = 0;
    while (m1_edges < 7 && k < 60) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (m1_edges != 7) begin
      errors++;
      $display("[TB] FAIL mid_edges: got %0d want 7", m1_edges);
    end
    rst_n = 1'b0;
    #1;
    got = {bus1.dac_sync, bus1.dac_sclk, bus1.dac_din, bus1.dac_done, bus1.dac_ready};
    checks++;
    if (got !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL mid_reset_pins: got %b want 11001", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m1_frames.delete();
    m1_fedges.delete();
    bus1.dac_data  = 8'h81;
    bus1.dac_pd    = PD_NORMAL;
    bus1.dac_valid = 1'b1;
    @(negedge clk);
    bus1.dac_valid = 1'b0;
    wait_frames1(1, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL mid_timeout: got no frame want 1 frame");
    end else begin
      checks++;
      if (m1_frames[0] !== 16'h0810 || m1_fedges[0] != 16) begin
        errors++;
        $display("[TB] FAIL mid_word: got %h/%0d want 0810/16", m1_frames[0], m1_fedges[0]);
      end
    end
  endtask

  initial begin
    bus1.dac_valid = 1'b0;
    bus1.dac_data  = '0;
    bus1.dac_pd    = '0;
    bus4.dac_valid = 1'b0;
    bus4.dac_data  = '0;
    bus4.dac_pd    = '0;
    test_reset();
    test_single();
    test_ff_change();
    test_back_to_back();
    test_random();
    test_clkdiv4();
    test_midframe_reset();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
